// File: rtl/decoder_pkg.sv
// Shared constants, state encoding and helpers for the decoder scan sequencer.
package decoder_pkg;

   localparam int          DEC_W    = 4;
   localparam int          DEC_N    = 16;
   localparam logic [15:0] DEF_MASK = 16'hC2CA;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   // Number of set bits in a 16-bit truth table; 5 bits so 16 fits.
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + 5'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/decoder4t16.sv
// 4-to-16 line decoder with enable; line k is high when en=1 and w=k.
module decoder4t16
   import decoder_pkg::*;
(
   input  logic             en,
   input  logic [DEC_W-1:0] w,
   output logic [DEC_N-1:0] y
);

   generate
      for (genvar gi = 0; gi < DEC_N; gi++) begin : g_line
         assign y[gi] = en && (w == DEC_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Sweeps decoder4t16 through all codes, capturing f = |(y & mask) per code,
// then reports the truth table, its popcount and a compare against an expected table.
module decoder_scan_ctrl #(
   parameter int          SETTLE   = 1,
   parameter logic [15:0] DEF_MASK = decoder_pkg::DEF_MASK
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] mask,
   input  logic [15:0] expected,
   output logic        en,
   output logic [3:0]  w,
   output logic        busy,
   output logic        done,
   output logic [15:0] truth_table,
   output logic [4:0]  ones,
   output logic        match
);
   import decoder_pkg::*;

   localparam int             DW         = $clog2(SETTLE) + 1;
   localparam logic [DW-1:0]  DWELL_LAST = DW'(SETTLE - 1);

   scan_state_t          state_reg;
   logic [DW-1:0]        dwell_reg;
   logic [DEC_N-1:0]     mask_l_reg;
   logic [DEC_N-1:0]     expect_l_reg;
   logic [DEC_N-1:0]     table_reg;
   logic                 en_reg;
   logic                 busy_reg;
   logic                 done_reg;
   logic                 match_reg;
   logic [DEC_W-1:0]     w_reg;
   logic [4:0]           ones_reg;

   logic [DEC_N-1:0]     y;
   logic                 f;

   decoder4t16 u_dec (
      .en (en_reg),
      .w  (w_reg),
      .y  (y)
   );

   assign f = |(y & mask_l_reg);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         dwell_reg    <= '0;
         mask_l_reg   <= DEF_MASK;
         expect_l_reg <= '0;
         table_reg    <= '0;
         en_reg       <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         match_reg    <= 1'b0;
         w_reg        <= '0;
         ones_reg     <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && !abort) begin
                  mask_l_reg   <= mask;
                  expect_l_reg <= expected;
                  table_reg    <= '0;
                  dwell_reg    <= '0;
                  w_reg        <= '0;
                  en_reg       <= 1'b1;
                  busy_reg     <= 1'b1;
                  state_reg    <= SCAN;
               end
            end
            SCAN: begin
               // An abort drops any capture that would land on the same edge.
               if (abort) begin
                  state_reg <= IDLE;
                  en_reg    <= 1'b0;
                  busy_reg  <= 1'b0;
                  w_reg     <= '0;
                  dwell_reg <= '0;
               end else if (dwell_reg == DWELL_LAST) begin
                  table_reg[w_reg] <= f;
                  dwell_reg        <= '0;
                  if (w_reg == DEC_W'(DEC_N - 1)) begin
                     en_reg    <= 1'b0;
                     state_reg <= DONE;
                  end else begin
                     w_reg <= w_reg + DEC_W'(1);
                  end
               end else begin
                  dwell_reg <= dwell_reg + DW'(1);
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               w_reg     <= '0;
               if (!abort) begin
                  ones_reg  <= popcount16(table_reg);
                  match_reg <= (table_reg == expect_l_reg);
                  done_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               en_reg    <= 1'b0;
               busy_reg  <= 1'b0;
               w_reg     <= '0;
            end
         endcase
      end
   end

   assign en          = en_reg;
   assign w           = w_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign truth_table = table_reg;
   assign ones        = ones_reg;
   assign match       = match_reg;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: one instance with SETTLE=1, one with SETTLE=3.
module tb_decoder_scan_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [15:0] mask;
   logic [15:0] expected;

   logic        en1, busy1, done1, match1;
   logic [3:0]  w1;
   logic [15:0] table1;
   logic [4:0]  ones1;

   logic        en3, busy3, done3, match3;
   logic [3:0]  w3;
   logic [15:0] table3;
   logic [4:0]  ones3;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt  = 0;
   int done3_cnt = 0;
   int d0;

   always #5 clock = ~clock;

   decoder_scan_ctrl #(.SETTLE(1)) dut1 (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .mask        (mask),
      .expected    (expected),
      .en          (en1),
      .w           (w1),
      .busy        (busy1),
      .done        (done1),
      .truth_table (table1),
      .ones        (ones1),
      .match       (match1)
   );

   decoder_scan_ctrl #(.SETTLE(3)) dut3 (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .mask        (mask),
      .expected    (expected),
      .en          (en3),
      .w           (w3),
      .busy        (busy3),
      .done        (done3),
      .truth_table (table3),
      .ones        (ones3),
      .match       (match3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
      if (done1) done_cnt++;
      if (done3) done3_cnt++;
   endtask

   // Full SETTLE=1 scan; returns positioned in the Done cycle.
   task automatic run_scan(input logic [15:0] m, input logic [15:0] e, input string tag);
      mask     = m;
      expected = e;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (16) tick();
      check({tag, "_done_state_busy"}, 32'(busy1), 32'd1);
      check({tag, "_done_state_done"}, 32'(done1), 32'd0);
      tick();
      check({tag, "_done_pulse"}, 32'(done1), 32'd1);
      $display("scan %s: mask=%h expect=%h table=%h ones=%0d match=%0d", tag, m, e, table1, ones1, match1);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      mask     = 16'h0000;
      expected = 16'h0000;
      tick();
      tick();
      check("rst_en",    32'(en1),    32'd0);
      check("rst_w",     32'(w1),     32'd0);
      check("rst_busy",  32'(busy1),  32'd0);
      check("rst_done",  32'(done1),  32'd0);
      check("rst_table", 32'(table1), 32'd0);
      check("rst_ones",  32'(ones1),  32'd0);
      check("rst_match", 32'(match1), 32'd0);
      reset = 1'b0;
      tick();

      // T1: default-style mask, one code per cycle, Done at cycle 18
      mask     = 16'hC2CA;
      expected = 16'hC2CA;
      start    = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check("t1_w",    32'(w1),    32'(k));
         check("t1_en",   32'(en1),   32'd1);
         check("t1_busy", 32'(busy1), 32'd1);
         tick();
      end
      check("t1_done_state_en",   32'(en1),   32'd0);
      check("t1_done_state_busy", 32'(busy1), 32'd1);
      check("t1_done_state_done", 32'(done1), 32'd0);
      tick();
      check("t1_done",  32'(done1),  32'd1);
      check("t1_busy0", 32'(busy1),  32'd0);
      check("t1_table", 32'(table1), 32'hC2CA);
      check("t1_ones",  32'(ones1),  32'd7);
      check("t1_match", 32'(match1), 32'd1);
      $display("T1: table=%h ones=%0d match=%0d", table1, ones1, match1);
      tick();
      check("t1_done_pulse_end", 32'(done1), 32'd0);

      // T2: all minterms, expected differs in bit 0
      run_scan(16'hFFFF, 16'hFFFE, "t2");
      check("t2_table", 32'(table1), 32'hFFFF);
      check("t2_ones",  32'(ones1),  32'd16);
      check("t2_match", 32'(match1), 32'd0);
      tick();

      // T3: SETTLE=3 instance, each code held 3 cycles, Done at cycle 50
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      mask     = 16'h0000;
      expected = 16'h0000;
      start    = 1'b1;
      tick();
      start = 1'b0;
      d0 = done3_cnt;
      for (int k = 0; k < 16; k++) begin
         for (int d = 0; d < 3; d++) begin
            check("t3_w", 32'(w3), 32'(k));
            tick();
         end
      end
      check("t3_early_done", 32'(done3_cnt), 32'(d0));
      tick();
      check("t3_done",  32'(done3),  32'd1);
      check("t3_table", 32'(table3), 32'h0000);
      check("t3_ones",  32'(ones3),  32'd0);
      check("t3_match", 32'(match3), 32'd1);
      $display("T3: table=%h ones=%0d match=%0d", table3, ones3, match3);
      tick();

      // T4: abort on edge 5; set up ones=16/match=0 first so hold is visible
      run_scan(16'hFFFF, 16'hFFFE, "t4_pre");
      tick();
      mask     = 16'hC2CA;
      expected = 16'hC2CA;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_busy",  32'(busy1),  32'd0);
      check("t4_en",    32'(en1),    32'd0);
      check("t4_w",     32'(w1),     32'd0);
      check("t4_table", 32'(table1), 32'h000A);
      check("t4_ones",  32'(ones1),  32'd16);
      check("t4_match", 32'(match1), 32'd0);
      d0 = done_cnt;
      repeat (20) tick();
      check("t4_no_done", 32'(done_cnt), 32'(d0));
      $display("T4: table=%h ones=%0d match=%0d", table1, ones1, match1);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("t4_abort_beats_start", 32'(busy1), 32'd0);

      // T5a: Start held high through the whole scan
      d0       = done_cnt;
      mask     = 16'hFFFF;
      expected = 16'hFFFF;
      start    = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) begin
         check("t5_w_held_start", 32'(w1), 32'(k));
         tick();
      end
      start = 1'b0;
      tick();
      check("t5_one_done", 32'(done_cnt), 32'(d0 + 1));
      tick();
      check("t5_idle_after", 32'(busy1), 32'd0);
      check("t5_done_cnt",   32'(done_cnt), 32'(d0 + 1));
      $display("T5a: scans=%0d table=%h match=%0d", done_cnt - d0, table1, match1);

      // T5b: reset at cycle 8 of a scan
      mask     = 16'hC2CA;
      expected = 16'hC2CA;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      check("t5_pre_reset_table", 32'(table1), 32'h004A);
      reset = 1'b1;
      tick();
      check("t5_rst_en",    32'(en1),    32'd0);
      check("t5_rst_w",     32'(w1),     32'd0);
      check("t5_rst_busy",  32'(busy1),  32'd0);
      check("t5_rst_done",  32'(done1),  32'd0);
      check("t5_rst_table", 32'(table1), 32'd0);
      check("t5_rst_ones",  32'(ones1),  32'd0);
      check("t5_rst_match", 32'(match1), 32'd0);
      reset = 1'b0;
      tick();

      // T6: Start in the Done cycle launches the next scan immediately
      d0 = done_cnt;
      run_scan(16'hC2CA, 16'hC2CA, "t6a");
      mask     = 16'hFFFF;
      expected = 16'h0000;
      start    = 1'b1;
      check("t6_table_held", 32'(table1), 32'hC2CA);
      tick();
      start = 1'b0;
      check("t6_busy",  32'(busy1),  32'd1);
      check("t6_en",    32'(en1),    32'd1);
      check("t6_w",     32'(w1),     32'd0);
      check("t6_clear", 32'(table1), 32'd0);
      repeat (16) tick();
      tick();
      check("t6_done",     32'(done1),    32'd1);
      check("t6_done_cnt", 32'(done_cnt), 32'(d0 + 2));
      check("t6_table",    32'(table1),   32'hFFFF);
      check("t6_ones",     32'(ones1),    32'd16);
      check("t6_match",    32'(match1),   32'd0);
      $display("T6: table=%h ones=%0d match=%0d", table1, ones1, match1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
